// File: rtl/diff_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : diff_serial_tx_pkg
// Brief   : State encodings and counter-width helper shared by diff_serial_tx.
//           Optional feature macro: DIFF_SERIAL_TX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
package diff_serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/diff_serial_tx_bit_tick.sv
`default_nettype none
// ============================================================================
// Module  : diff_serial_tx_bit_tick
// Brief   : CLKS_PER_BIT cycle counter; TICK marks the last cycle of a bit.
// Revision: 1.0 - initial release
// ============================================================================
module diff_serial_tx_bit_tick
    import diff_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic TICK
);

    localparam int                 c_cnt_w = cnt_width(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign TICK = EN && (r_cnt == c_last);

    always_ff @(posedge CLK) begin
        if (RST || !EN) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/diff_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : diff_serial_tx
// Brief   : Framed serialiser (start/data/[parity]/stop) onto a complementary
//           O/OB pair. Parity bit enabled by DIFF_SERIAL_TX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module diff_serial_tx
    import diff_serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit LSB_FIRST    = 1'b1,
    parameter bit IDLE_LEVEL   = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    output logic                  O,
    output logic                  OB,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int                     c_bit_cnt_w = cnt_width(DATA_WIDTH);
    localparam logic [c_bit_cnt_w-1:0] c_last_bit  = c_bit_cnt_w'(DATA_WIDTH - 1);

    state_t                  r_state, w_state_next;
    logic [DATA_WIDTH-1:0]   r_shift, w_shift_next;
    logic [c_bit_cnt_w-1:0]  r_bit_cnt, w_bit_cnt_next;
    logic                    r_o, w_o_next;
    logic                    w_tick, w_busy, w_accept, w_head;
`ifdef DIFF_SERIAL_TX_PARITY_EN
    logic                    r_parity;
`endif

    diff_serial_tx_bit_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_tick (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (w_busy),
        .TICK (w_tick)
    );

    assign w_busy    = (r_state != IDLE);
    // Ready in the last STOP cycle lets the next frame start with no idle gap.
    assign DIN_READY = !RST && ((r_state == IDLE) || ((r_state == STOP) && w_tick));
    assign w_accept  = DIN_VALID && DIN_READY;
    assign BUSY      = w_busy;
    assign DONE      = (r_state == STOP) && w_tick;
    assign O         = r_o;
    assign OB        = ~r_o;

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        case (r_state)
            IDLE:  if (w_accept) w_state_next = START;
            START: if (w_tick)   w_state_next = DATA;
            DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_last_bit) begin
`ifdef DIFF_SERIAL_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_shift_next   = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef DIFF_SERIAL_TX_PARITY_EN
            PARITY: if (w_tick) w_state_next = STOP;
`endif
            STOP:  if (w_tick) w_state_next = w_accept ? START : IDLE;
            default: w_state_next = IDLE;
        endcase
        if (w_accept) begin
            w_shift_next   = DIN;
            w_bit_cnt_next = '0;
        end
    end

    // Line level is decided one cycle ahead so O comes straight from a flop.
    assign w_head = LSB_FIRST ? w_shift_next[0] : w_shift_next[DATA_WIDTH-1];

    always_comb begin
        w_o_next = IDLE_LEVEL;
        case (w_state_next)
            START:  w_o_next = ~IDLE_LEVEL;
            DATA:   w_o_next = w_head;
`ifdef DIFF_SERIAL_TX_PARITY_EN
            PARITY: w_o_next = r_parity;
`endif
            default: w_o_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_o       <= IDLE_LEVEL;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_o       <= w_o_next;
        end
    end

`ifdef DIFF_SERIAL_TX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^DIN;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_diff_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_diff_serial_tx
// Brief   : Scoreboard bench for diff_serial_tx (LSB-first x1 and MSB-first x4
//           instances). Honours DIFF_SERIAL_TX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_diff_serial_tx;

    localparam bit c_idle = 1'b0;

    logic       clk = 1'b0;
    logic       r_rst = 1'b1;
    logic [7:0] r_din_a = 8'h00, r_din_b = 8'h00;
    logic       r_valid_a = 1'b0, r_valid_b = 1'b0;
    logic       w_ready_a, w_o_a, w_ob_a, w_busy_a, w_done_a;
    logic       w_ready_b, w_o_b, w_ob_b, w_busy_b, w_done_b;

    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    // Each entry is {expected O, expected DONE} for one busy cycle.
    logic [1:0] q_a[$];
    logic [1:0] q_b[$];

    always #5 clk = ~clk;

    diff_serial_tx #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1'b1), .IDLE_LEVEL(c_idle)
    ) u_dut_a (
        .CLK(clk), .RST(r_rst), .DIN(r_din_a), .DIN_VALID(r_valid_a),
        .DIN_READY(w_ready_a), .O(w_o_a), .OB(w_ob_a), .BUSY(w_busy_a), .DONE(w_done_a)
    );

    diff_serial_tx #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(c_idle)
    ) u_dut_b (
        .CLK(clk), .RST(r_rst), .DIN(r_din_b), .DIN_VALID(r_valid_b),
        .DIN_READY(w_ready_b), .O(w_o_b), .OB(w_ob_b), .BUSY(w_busy_b), .DONE(w_done_b)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic push_frame(input int sel, input logic [7:0] w);
        int         cpb;
        bit         lsb;
        logic       b;
        logic [1:0] e[$];
        cpb = (sel == 0) ? 1 : 4;
        lsb = (sel == 0);
        repeat (cpb) e.push_back({~c_idle, 1'b0});
        for (int i = 0; i < 8; i++) begin
            b = lsb ? w[i] : w[7-i];
            repeat (cpb) e.push_back({b, 1'b0});
        end
`ifdef DIFF_SERIAL_TX_PARITY_EN
        repeat (cpb) e.push_back({^w, 1'b0});
`endif
        for (int i = 0; i < cpb; i++) e.push_back({c_idle, (i == cpb - 1)});
        foreach (e[i]) begin
            if (sel == 0) q_a.push_back(e[i]);
            else          q_b.push_back(e[i]);
        end
    endtask

    task automatic mon_step(input string tag, input logic busy, input logic pending,
                            input logic have, input logic [1:0] e, input logic o,
                            input logic ob, input logic done, input logic ready);
        chk({tag, "_ob_complement"}, ob, ~o);
        if (busy) begin
            chk({tag, "_busy_expected"}, have, 1'b1);
            if (have) begin
                chk({tag, "_o"}, o, e[1]);
                chk({tag, "_done"}, done, e[0]);
                chk({tag, "_ready_busy"}, ready, e[0]);
            end
        end else begin
            chk({tag, "_no_gap"}, pending, 1'b0);
            chk({tag, "_o_idle"}, o, c_idle);
            chk({tag, "_done_idle"}, done, 1'b0);
            chk({tag, "_ready_idle"}, ready, ~r_rst);
        end
    endtask

    logic [1:0] e_a, e_b;
    logic       have_a, have_b, pend_a, pend_b;

    always @(negedge clk) begin
        if (mon_en) begin
            pend_a = (q_a.size() != 0);
            have_a = 1'b0;
            e_a    = 2'b00;
            if (w_busy_a && pend_a) begin
                e_a    = q_a.pop_front();
                have_a = 1'b1;
            end
            mon_step("a", w_busy_a, pend_a, have_a, e_a, w_o_a, w_ob_a, w_done_a, w_ready_a);
            pend_b = (q_b.size() != 0);
            have_b = 1'b0;
            e_b    = 2'b00;
            if (w_busy_b && pend_b) begin
                e_b    = q_b.pop_front();
                have_b = 1'b1;
            end
            mon_step("b", w_busy_b, pend_b, have_b, e_b, w_o_b, w_ob_b, w_done_b, w_ready_b);
        end
    end

    task automatic send(input int sel, input logic [7:0] w, input bit hold);
        bit ok = 1'b0;
        if (sel == 0) begin r_din_a = w; r_valid_a = 1'b1; end
        else          begin r_din_b = w; r_valid_b = 1'b1; end
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = (sel == 0) ? w_ready_a : w_ready_b;
        end
        chk("send_ready_seen", ok, 1'b1);
        if (ok) begin
            @(posedge clk);
            #1;
            push_frame(sel, w);
        end
        if (!hold || !ok) begin
            if (sel == 0) r_valid_a = 1'b0;
            else          r_valid_b = 1'b0;
        end
    endtask

    task automatic drain();
        bit empty = 1'b0;
        for (int n = 0; n < 400 && !empty; n++) begin
            @(posedge clk);
            empty = (q_a.size() == 0) && (q_b.size() == 0);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_complete", empty, 1'b1);
    endtask

    initial begin
        // Reset for 3 cycles, then 20 idle cycles.
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 r_rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Single LSB-first frame.
        send(0, 8'hA5, 1'b0);
        drain();

        // MSB-first, 4 clocks per bit.
        send(1, 8'h80, 1'b0);
        drain();

        // Back-to-back frames with DIN_VALID held high.
        send(0, 8'h01, 1'b1);
        send(0, 8'hFF, 1'b0);
        drain();

        // Reset during data bit 3 of 8'h3C, then a clean frame.
        send(0, 8'h3C, 1'b0);
        repeat (4) @(posedge clk);
        #1 r_rst = 1'b1;
        @(posedge clk);
        #1 q_a.delete();
        @(posedge clk);
        #1 r_rst = 1'b0;
        send(0, 8'h55, 1'b0);
        drain();

        // Parity-relevant words on both instances.
        send(0, 8'hA5, 1'b0);
        send(0, 8'h07, 1'b0);
        send(1, 8'h07, 1'b0);
        drain();

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/diff_serial_tx.md
Name: diff_serial_tx

Overview:
- Transmit-side partner of the differential input buffers in the library.
- Takes parallel words over a valid/ready handshake and serialises each word onto a complementary pair O/OB using a framed format: start bit, data bits, optional parity bit, stop bit.
- O and OB are never equal, so the receive buffer never sees an invalid or ambiguous state and never has to hold its last value.
- Sits at the pad boundary of any serial link driven from the fabric.

Parameters:
- DATA_WIDTH, 8: bits per word; legal range 1..32.
- CLKS_PER_BIT, 4: CLK cycles per serial bit; legal range 1..65535.
- LSB_FIRST, 1: 1 sends bit 0 first; 0 sends bit DATA_WIDTH-1 first.
- IDLE_LEVEL, 0: O level while idle and during the stop bit; the start bit is ~IDLE_LEVEL.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- DIN  input  DATA_WIDTH  word to send; sampled only on acceptance.
- DIN_VALID  input  1  DIN holds a word to send.
- DIN_READY  output  1  block can accept a word this cycle.
- O  output  1  serial line, positive leg.
- OB  output  1  serial line, negative leg; always ~O.
- BUSY  output  1  a frame is in progress (any state except IDLE).
- DONE  output  1  one-cycle pulse in the last CLK cycle of the stop bit.

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous and active-high.
- Reset values, taken at the first CLK edge with RST=1 and held while RST=1:
  - O=IDLE_LEVEL, OB=~IDLE_LEVEL.
  - DIN_READY=0, BUSY=0, DONE=0.
  - State IDLE; bit and cycle counters 0.
- Reset mid-frame: the frame is aborted with no DONE pulse. The line returns to idle level at that same edge, and the aborted word is discarded.
- Handshake:
  - A word is accepted on the rising edge where DIN_VALID && DIN_READY; DIN is latched into the shift register at that edge.
  - DIN_READY=1 in IDLE (RST=0) and in the final cycle of STOP; 0 otherwise.
  - DIN may change freely while DIN_READY=0.
- States and transitions:
  - IDLE: O=IDLE_LEVEL. On acceptance, go to START.
  - START: O=~IDLE_LEVEL for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: sends DATA_WIDTH bits, each held for CLKS_PER_BIT cycles, in the order set by LSB_FIRST. After the last bit, go to PARITY if the optional feature is enabled, otherwise STOP.
  - STOP: O=IDLE_LEVEL for CLKS_PER_BIT cycles.
    - On the last cycle, DONE=1.
    - If a word is accepted on that cycle, go to START; otherwise go to IDLE.
  - Back-to-back frames therefore have no idle gap.
- Latency:
  - With acceptance at edge k, the start bit appears on O after edge k, i.e. in cycle k+1.
  - Frame length is (DATA_WIDTH+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.
- Timing source: a cycle counter counts 0..CLKS_PER_BIT-1 and wraps. Its wrap marks each bit boundary. When CLKS_PER_BIT=1, every cycle is a boundary.
- Output register: O is driven from a flop and OB from the complement of the same flop. There is no combinational path from DIN to O.
- BUSY is 1 in START, DATA, PARITY and STOP.
- DIN_VALID while BUSY and not in the final cycle of STOP: held off by DIN_READY=0; no data is lost.

Optional Feature:
- Macro: DIFF_SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - O carries even parity (XOR of the accepted word), so the total count of ones across the data and parity bits is even.
- Undefined: no PARITY state, and no parity logic is present.

Decomposition:
- Package diff_serial_tx_pkg holds:
  - State encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit).
  - The counter width function (clog2), used for the cycle and bit counters.
- One sub-module, diff_serial_tx_bit_tick, implements the CLKS_PER_BIT cycle counter:
  - Inputs CLK, RST, EN; output TICK, high on the last cycle of each bit.
  - It is cleared on RST and whenever EN=0.

Test Plan:
- Reset, then idle:
  - RST=1 for 3 cycles, release, DIN_VALID=0 for 20 cycles -> O=0, OB=1 throughout.
  - DIN_READY=0 during reset and 1 from the first cycle after release.
- Single frame (DATA_WIDTH=8, CLKS_PER_BIT=1, LSB_FIRST=1, no parity):
  - Send DIN=8'hA5 -> O = 1 | 1,0,1,0,0,1,0,1 | 0 over 10 cycles.
  - DONE pulses in cycle 10; OB equals ~O in every cycle.
- MSB-first with bit stretching (LSB_FIRST=0, CLKS_PER_BIT=4):
  - Send DIN=8'h80 -> start bit 4 cycles high, then 4 cycles high (bit 7), then 28 cycles low, then stop 4 cycles low.
- Back-to-back frames:
  - Hold DIN_VALID=1 with 8'h01 then 8'hFF -> second start bit immediately follows the first stop bit.
  - No idle cycle between frames; DIN_READY high only in the final STOP cycle; two DONE pulses exactly 10 cycles apart.
- Reset mid-frame:
  - Assert RST during DATA bit 3 of 8'h3C -> O=0, OB=1 at that edge; no DONE pulse.
  - After release, the next accepted word 8'h55 is sent correctly.
- Parity (DIFF_SERIAL_TX_PARITY_EN defined):
  - 8'hA5 -> parity bit 0.
  - 8'h07 -> parity bit 1.
  - Frame length is 11 cycles at CLKS_PER_BIT=1.
